serial_subtractor: RTL

- Bit-serial N-bit subtractor: computes d = a − b, one bit per clock, LSB first, with a single borrow register.
- Pairs with the structural full-adder datapath as its arithmetic inverse.
- Sits beside the adder in the arithmetic library as the area-minimal subtract unit.
- Uses a start/busy/done handshake so a controller can issue operations and collect results.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_subtractor_full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and the counter-width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from gate primitives.
// Structural twin of the full-adder cell: d = x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic bout,
    output logic d
);

    logic t;
    logic xn;
    logic tn;
    logic p;
    logic q;

    xor g_x0 (t, x, y);
    xor g_x1 (d, t, bin);
    not g_n0 (xn, x);
    not g_n1 (tn, t);
    and g_a0 (p, xn, y);
    and g_a1 (q, tn, bin);
    or  g_o0 (bout, p, q);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor d = a - b, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             diff;
    logic             br_nx;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits, kept because the shifters lose them
    logic [1:0]       msb;
`endif

    full_subtractor u_fs (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (br),
        .bout (br_nx),
        .d    (diff)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            msb   <= 2'b00;
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        msb   <= {a[WIDTH-1], b[WIDTH-1]};
`endif
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_nx;
                    r_sh <= {diff, r_sh[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        d     <= {diff, r_sh[WIDTH-1:1]};
                        bout  <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (msb[1] ^ msb[0]) & (diff ^ msb[1]);
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
